// File: rtl/shift_compare_checker_pkg.sv
// Shared types and helpers for the shift-register comparison checker.
package shift_compare_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [7:0] ERR_NONE = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_compare_checker_expect_delay_line.sv
// Reference delay line: predicts what an ideal one- or two-stage register chain
// should present, plus a fill counter telling when the prediction is trustworthy.
module expect_delay_line
    import shift_compare_checker_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int C_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b_exp,
    output logic [WIDTH-1:0] c_exp,
    output logic             hist_ok
);

    localparam logic [1:0] FILL_NEED = 2'(C_LAT);

    logic [WIDTH-1:0] h0_q, h0_d;
    logic [WIDTH-1:0] h1_q, h1_d;
    logic [1:0]       fill_q, fill_d;

    // History shifts unconditionally; fill saturates so it never wraps to "empty".
    always_comb begin
        h0_d = a;
        h1_d = h0_q;
        if (fill_q == 2'd3) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + 2'd1;
        end
    end

    // History and fill registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            h0_q   <= '0;
            h1_q   <= '0;
            fill_q <= 2'd0;
        end else begin
            h0_q   <= h0_d;
            h1_q   <= h1_d;
            fill_q <= fill_d;
        end
    end

    assign b_exp   = h0_q;
    assign c_exp   = (C_LAT == 1) ? h0_q : h1_q;
    assign hist_ok = (fill_q >= FILL_NEED);

endmodule

// File: rtl/shift_compare_checker.sv
// Run-based monitor: compares DUT stage outputs against a local delay line over
// a fixed window and reports per-output mismatch counts and the first failing index.
module shift_compare_checker
    import shift_compare_checker_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int C_LAT      = 2,
    parameter int NUM_CHECKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_b_cnt,
    output logic [7:0]       err_c_cnt,
    output logic [7:0]       first_err_idx
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_CHECKS - 1);

    state_e     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] err_b_q, err_b_d;
    logic [7:0] err_c_q, err_c_d;
    logic [7:0] first_q, first_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic [WIDTH-1:0] b_exp, c_exp;
    logic             hist_ok;
    logic             b_mis, c_mis;

    expect_delay_line #(
        .WIDTH (WIDTH),
        .C_LAT (C_LAT)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b_exp   (b_exp),
        .c_exp   (c_exp),
        .hist_ok (hist_ok)
    );

    // Case inequality so an X from the DUT is reported rather than silently matched.
    assign b_mis = (b_in !== b_exp);
    assign c_mis = (c_in !== c_exp);

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_b_d = err_b_q;
        err_c_d = err_c_q;
        first_d = first_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WARMUP;
                    idx_d   = 8'd0;
                    err_b_d = 8'd0;
                    err_c_d = 8'd0;
                    first_d = ERR_NONE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WARMUP: begin
                if (hist_ok) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_WARMUP;
                end
            end
            ST_CHECK: begin
                if (b_mis) begin
                    err_b_d = sat_inc(err_b_q);
                end else begin
                    err_b_d = err_b_q;
                end
                if (c_mis) begin
                    err_c_d = sat_inc(err_c_q);
                end else begin
                    err_c_d = err_c_q;
                end
                if ((b_mis || c_mis) && (first_q == ERR_NONE)) begin
                    first_d = idx_q;
                end else begin
                    first_d = first_q;
                end
                idx_d = idx_q + 8'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_WARMUP) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_b_d == 8'd0) && (err_c_d == 8'd0);
    end

    // State, counters and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'd0;
            err_b_q <= 8'd0;
            err_c_q <= 8'd0;
            first_q <= ERR_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_b_q <= err_b_d;
            err_c_q <= err_c_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_b_cnt     = err_b_q;
    assign err_c_cnt     = err_c_q;
    assign first_err_idx = first_q;

endmodule
